// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte port between NUM_REQ sources, with packet lock.
// Optional header byte per grant when UART_TX_ARB_HEADER_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MAX_PKT_LEN = 64,
  parameter logic [4:0]  HDR_TAG     = 5'h1A
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
  output logic                         busy,
  output logic                         trunc_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_LOCK} state_t;

  state_t          r_state, w_state_n;
  logic [IW-1:0]   r_rr_ptr, w_rr_n;
  logic [IW-1:0]   r_grant_idx, w_gidx_n;
  logic [CW-1:0]   r_byte_cnt, w_cnt_n;
  logic            r_trunc, w_trunc_n;

  logic [NUM_REQ-1:0][7:0] w_data;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_at_limit;
  logic            w_xfer;
  logic            w_unused_hdr;

  assign w_data       = req_data;
  assign w_unused_hdr = ^HDR_TAG;
  assign w_cnt_inc    = r_byte_cnt + CW'(1);
  assign w_at_limit   = (w_cnt_inc == CW'(MAX_PKT_LEN));

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
    return IW'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!w_found && req_valid[f_wrap(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = f_wrap(r_rr_ptr, k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
      r_byte_cnt  <= '0;
      r_trunc     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_rr_ptr    <= w_rr_n;
      r_grant_idx <= w_gidx_n;
      r_byte_cnt  <= w_cnt_n;
      r_trunc     <= w_trunc_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_rr_n    = r_rr_ptr;
    w_gidx_n  = r_grant_idx;
    w_cnt_n   = r_byte_cnt;
    w_trunc_n = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    req_ready = '0;
    w_xfer    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gidx_n = w_pick;
          w_cnt_n  = '0;
`ifdef UART_TX_ARB_HEADER_EN
          w_state_n = S_HDR;
`else
          w_state_n = S_LOCK;
`endif
        end
      end
`ifdef UART_TX_ARB_HEADER_EN
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = {HDR_TAG, 3'(r_grant_idx)};
        if (tx_ready) w_state_n = S_LOCK;
      end
`endif
      S_LOCK: begin
        tx_valid               = req_valid[r_grant_idx];
        tx_data                = w_data[r_grant_idx];
        req_ready[r_grant_idx] = tx_ready;
        w_xfer                 = tx_valid & tx_ready;
        if (w_xfer) begin
          w_cnt_n = w_cnt_inc;
          // Last byte wins over the length limit: no truncation reported then
          if (req_last[r_grant_idx] || w_at_limit) begin
            w_state_n = S_IDLE;
            w_rr_n    = f_wrap(r_grant_idx, 1);
            w_trunc_n = !req_last[r_grant_idx];
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign grant_idx   = r_grant_idx;
  assign trunc_pulse = r_trunc;
endmodule
